// File: rtl/spmv_row_acc_ctrl.sv
// Purpose: serial fp16 row accumulator sequencing a shared adder, one product in flight at a time.
// Latency: ADD_LAT+2 cycles per product, plus >=1 OUT cycle per row sum.
// Backpressure: o_prod_ready low while an add is in flight or a row sum waits for i_row_ready.
// Build option: define SPMV_ZERO_SKIP_EN to let +/-0 products bypass the adder.
module spmv_row_acc_ctrl #(
    parameter int ADD_LAT = 2,
    parameter int ROW_W   = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_prod_valid,
    output logic             o_prod_ready,
    input  logic [15:0]      i_prod,
    input  logic             i_prod_last,
    output logic [15:0]      o_add_a,
    output logic [15:0]      o_add_b,
    output logic             o_add_valid,
    input  logic [15:0]      i_add_result,
    output logic             o_row_valid,
    input  logic             i_row_ready,
    output logic [15:0]      o_row_sum,
    output logic [ROW_W-1:0] o_row_idx,
    output logic             o_busy
);

    // Counter only has to hold ADD_LAT-1; keep it at least one bit wide for ADD_LAT==1.
    localparam int CNT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ADD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t           state;
    logic [15:0]      acc;
    logic             last_q;
    logic [CNT_W-1:0] cnt;
    logic [ROW_W-1:0] row_idx;
    logic             prod_skip;

`ifdef SPMV_ZERO_SKIP_EN
    // Either signed zero leaves the running sum unchanged, so it never needs the adder.
    assign prod_skip = (i_prod[14:0] == 15'd0);
`else
    assign prod_skip = 1'b0;
`endif

    assign o_row_idx = row_idx;
    assign o_busy    = (state != IDLE) || (acc != 16'h0000);

    // Row accumulation FSM; every output except row index and busy is registered here.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            acc          <= 16'h0000;
            last_q       <= 1'b0;
            cnt          <= '0;
            row_idx      <= '0;
            o_prod_ready <= 1'b0;
            o_add_a      <= 16'h0000;
            o_add_b      <= 16'h0000;
            o_add_valid  <= 1'b0;
            o_row_valid  <= 1'b0;
            o_row_sum    <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (i_prod_valid && o_prod_ready) begin
                        last_q <= i_prod_last;
                        if (prod_skip) begin
                            // Bypassed zero: accumulator untouched, stay ready unless the row ends.
                            if (i_prod_last) begin
                                state        <= OUT;
                                o_prod_ready <= 1'b0;
                                o_row_valid  <= 1'b1;
                                o_row_sum    <= acc;
                            end
                        end else begin
                            o_add_a      <= i_prod;
                            o_add_b      <= acc;
                            o_add_valid  <= 1'b1;
                            o_prod_ready <= 1'b0;
                            state        <= ISSUE;
                        end
                    end else begin
                        o_prod_ready <= 1'b1;
                    end
                end
                ISSUE: begin
                    o_add_valid <= 1'b0;
                    cnt         <= CNT_LOAD;
                    state       <= WAIT;
                end
                WAIT: begin
                    // Operands stay put; result is taken ADD_LAT cycles after the ISSUE cycle.
                    if (cnt == '0) begin
                        acc <= i_add_result;
                        if (last_q) begin
                            state       <= OUT;
                            o_row_valid <= 1'b1;
                            o_row_sum   <= i_add_result;
                        end else begin
                            state        <= IDLE;
                            o_prod_ready <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                OUT: begin
                    if (i_row_ready) begin
                        o_row_valid  <= 1'b0;
                        acc          <= 16'h0000;
                        row_idx      <= row_idx + ROW_W'(1);
                        o_prod_ready <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spmv_row_acc_ctrl.sv
// Purpose: directed self-checking bench for spmv_row_acc_ctrl with a behavioural delayed fp16 adder.
// Latency: adder model returns a+b ADD_LAT edges after the operands are first presented.
// Backpressure: i_row_ready is held low in one sequence; otherwise tied high.
module tb_spmv_row_acc_ctrl;

    localparam int ADD_LAT = 2;
    localparam int ROW_W   = 8;

    logic             i_clk;
    logic             i_rst;
    logic             i_prod_valid;
    logic             o_prod_ready;
    logic [15:0]      i_prod;
    logic             i_prod_last;
    logic [15:0]      o_add_a;
    logic [15:0]      o_add_b;
    logic             o_add_valid;
    logic [15:0]      i_add_result;
    logic             o_row_valid;
    logic             i_row_ready;
    logic [15:0]      o_row_sum;
    logic [ROW_W-1:0] o_row_idx;
    logic             o_busy;

    spmv_row_acc_ctrl #(.ADD_LAT(ADD_LAT), .ROW_W(ROW_W)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_prod_valid (i_prod_valid),
        .o_prod_ready (o_prod_ready),
        .i_prod       (i_prod),
        .i_prod_last  (i_prod_last),
        .o_add_a      (o_add_a),
        .o_add_b      (o_add_b),
        .o_add_valid  (o_add_valid),
        .i_add_result (i_add_result),
        .o_row_valid  (o_row_valid),
        .i_row_ready  (i_row_ready),
        .o_row_sum    (o_row_sum),
        .o_row_idx    (o_row_idx),
        .o_busy       (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pulse_total = 0;
    logic [15:0] qa [$];
    logic [15:0] qb [$];
    int          acc_q [$];

    // fp16 <-> real helpers, adequate for the normal and zero values used here.
    function automatic real h2r(input logic [15:0] h);
        int  e;
        real r;
        e = int'(h[14:10]);
        r = real'(h[9:0]) / 1024.0;
        if (e == 0) e = 1;
        else r = r + 1.0;
        for (int i = 15; i < e; i++) r = r * 2.0;
        for (int i = e; i < 15; i++) r = r / 2.0;
        return h[15] ? -r : r;
    endfunction

    function automatic logic [15:0] r2h(input real r);
        logic        s;
        real         a;
        int          e;
        logic [15:0] m;
        logic [4:0]  ef;
        if (r == 0.0) return 16'h0000;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 15;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        m  = 16'($rtoi((a - 1.0) * 1024.0 + 0.5));
        ef = e[4:0];
        return {s, ef, m[9:0]};
    endfunction

    // Behavioural adder: ADD_LAT-deep pipeline of a+b.
    logic [15:0] pipe [ADD_LAT];
    always @(posedge i_clk) begin
        pipe[0] <= r2h(h2r(o_add_a) + h2r(o_add_b));
        for (int k = 1; k < ADD_LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign i_add_result = pipe[ADD_LAT-1];

    always @(posedge i_clk) cyc <= cyc + 1;

    // Record every ISSUE strobe and the operands shown with it.
    always @(negedge i_clk) begin
        if (o_add_valid) begin
            pulse_total++;
            qa.push_back(o_add_a);
            qb.push_back(o_add_b);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    // Starts and ends on a negedge; returns just after the accepting edge.
    task automatic send(input logic [15:0] p, input logic l);
        int w = 0;
        i_prod = p; i_prod_last = l; i_prod_valid = 1'b1;
        while (!o_prod_ready && w < 100) begin @(negedge i_clk); w++; end
        if (w >= 100) fail_timeout("send");
        acc_q.push_back(cyc);
        @(negedge i_clk);
        i_prod_valid = 1'b0; i_prod_last = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        int w = 0;
        while (!o_row_valid && w < 100) begin @(negedge i_clk); w++; end
        ok = o_row_valid;
        if (!ok) fail_timeout("row_valid");
    endtask

    task automatic wait_row(input logic [15:0] sum, input int idx, input bit advance);
        bit ok;
        wait_valid(ok);
        if (ok) begin
            check("row_sum", {16'h0, o_row_sum}, {16'h0, sum});
            check("row_idx", 32'(o_row_idx), 32'(idx));
        end
        if (advance) @(negedge i_clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_prod_ready"}, 32'(o_prod_ready), 0);
        check({tag, "_add_valid"},  32'(o_add_valid),  0);
        check({tag, "_add_a"},      32'(o_add_a),      0);
        check({tag, "_add_b"},      32'(o_add_b),      0);
        check({tag, "_row_valid"},  32'(o_row_valid),  0);
        check({tag, "_row_sum"},    32'(o_row_sum),    0);
        check({tag, "_row_idx"},    32'(o_row_idx),    0);
        check({tag, "_busy"},       32'(o_busy),       0);
    endtask

    typedef struct {
        int               n;
        logic [2:0][15:0] p;
        logic [15:0]      sum;
        int               pulses;
    } row_vec_t;

    function automatic row_vec_t mk(input int n, input logic [15:0] a, input logic [15:0] b,
                                    input logic [15:0] c, input logic [15:0] sum, input int pulses);
        row_vec_t v;
        v.n = n; v.p[0] = a; v.p[1] = b; v.p[2] = c; v.sum = sum; v.pulses = pulses;
        return v;
    endfunction

    row_vec_t rv [5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_idx;
        int p_start, q_start, a_start;
        int idx_err, per_err, prev_cyc, idx255, idx256;
        bit ok;

        i_rst = 1'b1; i_prod_valid = 1'b0; i_prod = 16'h0; i_prod_last = 1'b0; i_row_ready = 1'b1;

        rv[0] = mk(2, 16'h4C00, 16'h4000, 16'h0000, 16'h4C80, 2);  // 16+2 = 18
        rv[1] = mk(2, 16'h5400, 16'h4C00, 16'h0000, 16'h5500, 2);  // 64+16 = 80
`ifdef SPMV_ZERO_SKIP_EN
        rv[2] = mk(3, 16'h0000, 16'h8000, 16'h4000, 16'h4000, 1);  // zeros bypass
`else
        rv[2] = mk(3, 16'h0000, 16'h8000, 16'h4000, 16'h4000, 3);
`endif
        rv[3] = mk(1, 16'h3C00, 16'h0000, 16'h0000, 16'h3C00, 1);  // 1.0 + 0
        rv[4] = mk(2, 16'hC000, 16'h4000, 16'h0000, 16'h0000, 2);  // -2+2 = 0

        repeat (3) @(negedge i_clk);
        check_reset_outputs("reset");
        i_rst = 1'b0;
        @(negedge i_clk);

        // Table-driven rows.
        exp_idx = 0;
        for (int r = 0; r < 5; r++) begin
            p_start = pulse_total; q_start = qa.size(); a_start = acc_q.size();
            for (int k = 0; k < rv[r].n; k++) send(rv[r].p[k], (k == rv[r].n - 1));
            wait_row(rv[r].sum, exp_idx, 1'b1);
            check("add_pulses", 32'(pulse_total - p_start), 32'(rv[r].pulses));
            if (qb.size() > q_start) check("first_add_b_zero", 32'(qb[q_start]), 0);
            else fail_timeout("first_add_missing");
            if (r == 0) begin
                if (qa.size() > q_start + 1) begin
                    check("issue0_a", 32'(qa[q_start]),     32'h4C00);
                    check("issue1_a", 32'(qa[q_start + 1]), 32'h4000);
                    check("issue1_b", 32'(qb[q_start + 1]), 32'h4C00);
                end else fail_timeout("issue1_missing");
            end
            if (r == 2) begin
`ifdef SPMV_ZERO_SKIP_EN
                check("zero_accept_gap", 32'(acc_q[a_start + 1] - acc_q[a_start]), 1);
`else
                check("zero_accept_gap", 32'(acc_q[a_start + 1] - acc_q[a_start]), 32'(ADD_LAT + 2));
`endif
            end
            exp_idx++;
        end

        // Downstream stall: row sum held for 5 cycles, then released.
        i_row_ready = 1'b0;
        send(16'h3C00, 1'b1);
        wait_row(16'h3C00, 5, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge i_clk);
            check("hold_valid", 32'(o_row_valid), 1);
            check("hold_sum",   32'(o_row_sum),   32'h3C00);
            check("hold_idx",   32'(o_row_idx),   5);
            check("hold_ready", 32'(o_prod_ready), 0);
        end
        i_row_ready = 1'b1;
        @(negedge i_clk);
        check("release_valid", 32'(o_row_valid),  0);
        check("release_ready", 32'(o_prod_ready), 1);
        check("release_idx",   32'(o_row_idx),    6);

        // Reset while the second product's add is in flight.
        send(16'h4000, 1'b0);
        send(16'h4000, 1'b0);
        @(negedge i_clk);
        check("wait_busy", 32'(o_busy), 1);
        i_rst = 1'b1;
        @(negedge i_clk);
        check_reset_outputs("midrst");
        i_rst = 1'b0;
        send(16'h4000, 1'b1);
        wait_row(16'h4000, 0, 1'b1);

        // Wrap: 257 single-product rows from index 0, ready tied high.
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        idx_err = 0; per_err = 0; prev_cyc = 0; idx255 = -1; idx256 = -1;
        for (int k = 0; k < 257; k++) begin
            send(16'h3C00, 1'b1);
            wait_valid(ok);
            if (!ok) break;
            if (o_row_idx != k[7:0]) idx_err++;
            if (k == 255) idx255 = int'(o_row_idx);
            if (k == 256) idx256 = int'(o_row_idx);
            if (k > 0 && (cyc - prev_cyc) != ADD_LAT + 3) per_err++;
            prev_cyc = cyc;
            @(negedge i_clk);
        end
        check("wrap_idx_errors", 32'(idx_err), 0);
        check("row_period_errors", 32'(per_err), 0);
        check("idx_at_255", 32'(idx255), 255);
        check("idx_after_wrap", 32'(idx256), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
